// File: rtl/cache_ctrl_if.sv
// Signal bundle between the cache controller and its CPU, cache-way and memory neighbours.
// The slave modport is the controller's view; the master modport is the surrounding system.
interface cache_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      cpu_addr;
    logic             cpu_re;
    logic             cpu_we;
    logic             cpu_ready;

    logic [31:0]      way_addr;
    logic             way_re;
    logic             way_we;
    logic             way_done;
    logic             way_blk_write;
    logic [255:0]     way_blk_in;
    logic             way_hit;
    logic             way_dirty;
    logic [31:0]      way_orig_addr;
    logic [255:0]     way_blk_out;

    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [255:0]     mem_wdata;
    logic             mem_ack;
    logic [255:0]     mem_rdata;

    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    modport slave (
        input  cpu_addr, cpu_re, cpu_we,
        output cpu_ready,
        output way_addr, way_re, way_we, way_done, way_blk_write, way_blk_in,
        input  way_hit, way_dirty, way_orig_addr, way_blk_out,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output hit_cnt, miss_cnt
    );

    modport master (
        output cpu_addr, cpu_re, cpu_we,
        input  cpu_ready,
        input  way_addr, way_re, way_we, way_done, way_blk_write, way_blk_in,
        output way_hit, way_dirty, way_orig_addr, way_blk_out,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_ctrl.sv
// Blocking write-back, write-allocate controller for one cache way with 32-byte lines.
// Latency: hits complete in the request cycle; misses cost the memory waits plus 2 cycles.
// Backpressure: CPU holds its request until cpu_ready; mem_req and its payload hold until mem_ack.
module cache_ctrl #(
    parameter int CNT_W = 32
) (
    input logic         clk,
    input logic         rst,
    cache_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WB, REFILL, INSTALL} state_t;

    state_t           state;
    logic [26:0]      miss_addr;
    logic [255:0]     refill_buf;
    logic             retry;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [255:0]     mem_wdata_q;
    logic             blk_write_q;
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;

    logic cpu_req;
    logic in_idle;
    logic hit_now;
    logic miss_now;

    assign cpu_req  = bus.cpu_re | bus.cpu_we;
    assign in_idle  = (state == IDLE);
    assign hit_now  = in_idle & cpu_req & bus.way_hit;
    assign miss_now = in_idle & cpu_req & ~bus.way_hit;

    // A simultaneous read and write is a write, so way_re is suppressed when cpu_we is set.
    assign bus.cpu_ready     = hit_now;
    assign bus.way_done      = hit_now;
    assign bus.way_we        = in_idle & bus.cpu_we;
    assign bus.way_re        = in_idle & bus.cpu_re & ~bus.cpu_we;
    assign bus.way_addr      = in_idle ? bus.cpu_addr : {miss_addr, 5'd0};
    assign bus.way_blk_write = blk_write_q;
    assign bus.way_blk_in    = refill_buf;

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    assign bus.hit_cnt  = hit_cnt_q;
    assign bus.miss_cnt = miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            miss_addr   <= '0;
            refill_buf  <= '0;
            retry       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            blk_write_q <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            blk_write_q <= 1'b0;
            case (state)
                IDLE: begin
                    // The hit that follows an install is the original request finishing, not a new hit.
                    retry <= 1'b0;
                    if (hit_now && !retry && (hit_cnt_q != '1)) begin
                        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                    end
                    if (miss_now) begin
                        miss_addr <= bus.cpu_addr[31:5];
                        mem_req_q <= 1'b1;
                        if (miss_cnt_q != '1) begin
                            miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                        end
                        if (bus.way_dirty) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= bus.way_orig_addr & 32'hFFFF_FFE0;
                            mem_wdata_q <= bus.way_blk_out;
                            state       <= WB;
                        end else begin
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {bus.cpu_addr[31:5], 5'd0};
                            state      <= REFILL;
                        end
                    end
                end
                WB: begin
                    if (bus.mem_ack) begin
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {miss_addr, 5'd0};
                        state      <= REFILL;
                    end
                end
                REFILL: begin
                    if (bus.mem_ack) begin
                        mem_req_q   <= 1'b0;
                        refill_buf  <= bus.mem_rdata;
                        blk_write_q <= 1'b1;
                        state       <= INSTALL;
                    end
                end
                INSTALL: begin
                    retry <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural way and memory models plus a word-level golden memory image.
module tb_cache_ctrl;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_ctrl_if #(.CNT_W(CNT_W)) bus ();
    cache_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Direct-mapped way model: 8 sets, set = addr[7:5], tag = addr[31:8].
    logic         w_valid [8];
    logic         w_dirty [8];
    logic [23:0]  w_tag   [8];
    logic [255:0] w_data  [8];
    logic [2:0]   wset;
    assign wset              = bus.way_addr[7:5];
    assign bus.way_hit       = w_valid[wset] && (w_tag[wset] == bus.way_addr[31:8]);
    assign bus.way_dirty     = w_valid[wset] && w_dirty[wset];
    assign bus.way_orig_addr = {w_tag[wset], wset, 5'd0};
    assign bus.way_blk_out   = w_data[wset];

    logic [255:0] mem_store [logic [31:0]];
    logic [31:0]  golden    [logic [31:0]];

    int vectors = 0;
    int miscompares = 0;

    // Observations of one request, filled by run_req.
    int           lat;
    int           stab_bad;
    int           n_blk_write;
    logic         obs_we    [$];
    logic [31:0]  obs_addr  [$];
    logic [255:0] obs_wdata [$];
    logic [255:0] inst_blk;
    logic [31:0]  inst_way_addr;
    logic         rdy_done, rdy_we, rdy_re;
    logic [31:0]  rdy_word;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [255:0] mem_block(input logic [31:0] ba);
        logic [255:0] blk;
        if (mem_store.exists(ba)) return mem_store[ba];
        for (int i = 0; i < 8; i++) blk[i*32 +: 32] = init_word(ba + 32'(i * 4));
        return blk;
    endfunction

    function automatic logic [31:0] gold_word(input logic [31:0] a);
        if (golden.exists(a)) return golden[a];
        return init_word(a);
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        bus.cpu_addr  = '0;
        bus.cpu_re    = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            w_valid[i] = 1'b0;
            w_dirty[i] = 1'b0;
            w_tag[i]   = '0;
            w_data[i]  = '0;
        end
        golden.delete();
        mem_store.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic preload(input logic [31:0] ba, input logic dirty, input logic [255:0] data);
        logic [2:0] s;
        s = ba[7:5];
        w_valid[s] = 1'b1;
        w_dirty[s] = dirty;
        w_tag[s]   = ba[31:8];
        w_data[s]  = data;
        for (int i = 0; i < 8; i++) golden[{ba[31:5], 5'd0} + 32'(i * 4)] = data[i*32 +: 32];
    endtask

    // Issues one CPU request from a negedge, plays memory with the given waits, returns at a negedge.
    task automatic run_req(input logic [31:0] addr, input logic re, input logic we,
                           input logic [31:0] wdata, input int wbw, input int rfw);
        int           txn_cyc;
        int           wi;
        logic         cur_we, do_inst, do_wr;
        logic [31:0]  cur_addr, inst_addr_c;
        logic [255:0] cur_wd, inst_c;
        obs_we.delete(); obs_addr.delete(); obs_wdata.delete();
        stab_bad = 0; n_blk_write = 0; lat = -1; txn_cyc = 0;
        rdy_done = 1'b0; rdy_we = 1'b0; rdy_re = 1'b0; rdy_word = '0;
        cur_we = 1'b0; cur_addr = '0; cur_wd = '0;
        wi = int'(addr[4:2]);
        bus.cpu_addr = addr;
        bus.cpu_re   = re;
        bus.cpu_we   = we;
        for (int c = 0; c < 60; c++) begin
            #1;
            do_inst = bus.way_blk_write;
            do_wr   = 1'b0;
            inst_c  = bus.way_blk_in;
            inst_addr_c = bus.way_addr;
            if (do_inst) begin
                n_blk_write++;
                inst_blk = inst_c;
                inst_way_addr = inst_addr_c;
            end
            if (bus.mem_req) begin
                if (txn_cyc == 0) begin
                    obs_we.push_back(bus.mem_we);
                    obs_addr.push_back(bus.mem_addr);
                    obs_wdata.push_back(bus.mem_wdata);
                    cur_we = bus.mem_we; cur_addr = bus.mem_addr; cur_wd = bus.mem_wdata;
                end else if ({cur_we, cur_addr, cur_wd} !== {bus.mem_we, bus.mem_addr, bus.mem_wdata}) begin
                    stab_bad++;
                end
                txn_cyc++;
                if (txn_cyc >= (bus.mem_we ? wbw : rfw)) begin
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) mem_store[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = mem_block(bus.mem_addr);
                    txn_cyc = 0;
                end
            end
            if (bus.cpu_ready) begin
                lat      = c;
                rdy_done = bus.way_done;
                rdy_we   = bus.way_we;
                rdy_re   = bus.way_re;
                rdy_word = w_data[addr[7:5]][wi*32 +: 32];
                do_wr    = bus.way_we;
            end
            @(posedge clk);
            #1;
            if (do_inst) begin
                w_valid[inst_addr_c[7:5]] = 1'b1;
                w_dirty[inst_addr_c[7:5]] = 1'b0;
                w_tag[inst_addr_c[7:5]]   = inst_addr_c[31:8];
                w_data[inst_addr_c[7:5]]  = inst_c;
            end
            if (do_wr) begin
                w_data[addr[7:5]][wi*32 +: 32] = wdata;
                w_dirty[addr[7:5]] = 1'b1;
            end
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (lat >= 0) break;
        end
        bus.cpu_re = 1'b0;
        bus.cpu_we = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        vectors++;
        if ({bus.cpu_ready, bus.way_done, bus.way_blk_write, bus.mem_req} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 0000", {bus.cpu_ready, bus.way_done, bus.way_blk_write, bus.mem_req});
        end
        vectors++;
        if ({bus.hit_cnt, bus.miss_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_cnt hit %0d miss %0d want 0 0", bus.hit_cnt, bus.miss_cnt);
        end
        vectors++;
        if (bus.way_blk_in !== '0) begin
            miscompares++;
            $display("FAIL reset_refill_buf got %h want 0", bus.way_blk_in);
        end
        @(negedge clk);
    endtask

    task automatic test_hit();
        apply_reset();
        preload(32'h40, 1'b0, mem_block(32'h40));
        run_req(32'h40, 1'b1, 1'b0, 32'h0, 1, 1);
        vectors++;
        if (lat !== 0 || rdy_done !== 1'b1) begin
            miscompares++;
            $display("FAIL hit_latency got lat %0d done %b want 0 1", lat, rdy_done);
        end
        vectors++;
        if (obs_we.size() !== 0) begin
            miscompares++;
            $display("FAIL hit_no_mem got %0d requests want 0", obs_we.size());
        end
        vectors++;
        if (bus.hit_cnt !== CNT_W'(1) || bus.miss_cnt !== '0) begin
            miscompares++;
            $display("FAIL hit_cnt got hit %0d miss %0d want 1 0", bus.hit_cnt, bus.miss_cnt);
        end
        vectors++;
        if (rdy_word !== gold_word(32'h40)) begin
            miscompares++;
            $display("FAIL hit_data got %h want %h", rdy_word, gold_word(32'h40));
        end
    endtask

    task automatic test_clean_miss();
        apply_reset();
        preload(32'h40, 1'b0, mem_block(32'h40));
        run_req(32'h1040, 1'b1, 1'b0, 32'h0, 1, 3);
        vectors++;
        if (lat !== 5) begin
            miscompares++;
            $display("FAIL clean_latency got %0d want 5", lat);
        end
        vectors++;
        if (obs_we.size() !== 1) begin
            miscompares++;
            $display("FAIL clean_req_count got %0d want 1", obs_we.size());
        end else if ({obs_we[0], obs_addr[0]} !== {1'b0, 32'h1040}) begin
            miscompares++;
            $display("FAIL clean_req got we %b addr %h want 0 00001040", obs_we[0], obs_addr[0]);
        end
        vectors++;
        if (n_blk_write !== 1 || inst_blk !== mem_block(32'h1040) || inst_way_addr !== 32'h1040) begin
            miscompares++;
            $display("FAIL clean_install got %0d writes addr %h want 1 at 00001040 with refill data", n_blk_write, inst_way_addr);
        end
        vectors++;
        if (stab_bad !== 0) begin
            miscompares++;
            $display("FAIL clean_stable got %0d changes want 0", stab_bad);
        end
        vectors++;
        if (bus.miss_cnt !== CNT_W'(1) || bus.hit_cnt !== '0) begin
            miscompares++;
            $display("FAIL clean_cnt got hit %0d miss %0d want 0 1", bus.hit_cnt, bus.miss_cnt);
        end
        vectors++;
        if (rdy_word !== gold_word(32'h1040)) begin
            miscompares++;
            $display("FAIL clean_data got %h want %h", rdy_word, gold_word(32'h1040));
        end
    endtask

    task automatic test_dirty_write_miss();
        logic [255:0] old;
        logic [31:0]  wd;
        old = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        wd  = $urandom;
        apply_reset();
        preload(32'h40, 1'b1, old);
        run_req(32'h2044, 1'b0, 1'b1, wd, 2, 3);
        golden[32'h2044] = wd;
        vectors++;
        if (lat !== 7) begin
            miscompares++;
            $display("FAIL dirty_latency got %0d want 7", lat);
        end
        vectors++;
        if (obs_we.size() !== 2) begin
            miscompares++;
            $display("FAIL dirty_req_count got %0d want 2", obs_we.size());
        end else begin
            if ({obs_we[0], obs_addr[0], obs_wdata[0]} !== {1'b1, 32'h40, old}) begin
                miscompares++;
                $display("FAIL dirty_wb got we %b addr %h want 1 00000040 with old line", obs_we[0], obs_addr[0]);
            end
            if ({obs_we[1], obs_addr[1]} !== {1'b0, 32'h2040}) begin
                miscompares++;
                $display("FAIL dirty_refill got we %b addr %h want 0 00002040", obs_we[1], obs_addr[1]);
            end
        end
        vectors++;
        if ({rdy_done, rdy_we} !== 2'b11 || w_data[2][63:32] !== wd) begin
            miscompares++;
            $display("FAIL dirty_word_write got done %b we %b word %h want 1 1 %h", rdy_done, rdy_we, w_data[2][63:32], wd);
        end
        vectors++;
        if (mem_block(32'h40) !== old || stab_bad !== 0) begin
            miscompares++;
            $display("FAIL dirty_mem_image got stab %0d, old line %s memory", stab_bad, (mem_block(32'h40) === old) ? "in" : "not in");
        end
    endtask

    task automatic test_rw_both();
        logic [31:0] wd;
        wd = $urandom;
        apply_reset();
        preload(32'h40, 1'b0, mem_block(32'h40));
        run_req(32'h48, 1'b1, 1'b1, wd, 1, 1);
        vectors++;
        if (lat !== 0 || {rdy_we, rdy_re} !== 2'b10) begin
            miscompares++;
            $display("FAIL rw_as_write got lat %0d we %b re %b want 0 1 0", lat, rdy_we, rdy_re);
        end
        run_req(32'h48, 1'b1, 1'b0, 32'h0, 1, 1);
        vectors++;
        if (rdy_word !== wd || bus.hit_cnt !== CNT_W'(2)) begin
            miscompares++;
            $display("FAIL rw_readback got %h hit %0d want %h 2", rdy_word, bus.hit_cnt, wd);
        end
    endtask

    task automatic test_reset_mid_refill();
        int bad;
        apply_reset();
        preload(32'h40, 1'b0, mem_block(32'h40));
        bus.cpu_addr = 32'h1040;
        bus.cpu_re   = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h1040}) begin
            miscompares++;
            $display("FAIL rstmid_refill got req %b addr %h want 1 00001040", bus.mem_req, bus.mem_addr);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_req_drop got %b want 0", bus.mem_req);
        end
        bus.cpu_re = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_block(32'h1040);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.way_blk_write || bus.mem_req || bus.cpu_ready) bad++;
            @(negedge clk);
        end
        vectors++;
        if (bad !== 0 || {bus.hit_cnt, bus.miss_cnt} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_ignored got %0d active cycles hit %0d miss %0d want 0 0 0", bad, bus.hit_cnt, bus.miss_cnt);
        end
        run_req(32'h1040, 1'b1, 1'b0, 32'h0, 1, 2);
        vectors++;
        if (lat !== 4 || bus.miss_cnt !== CNT_W'(1)) begin
            miscompares++;
            $display("FAIL rstmid_fresh got lat %0d miss %0d want 4 1", lat, bus.miss_cnt);
        end
    endtask

    task automatic test_spurious_ack();
        apply_reset();
        preload(32'h40, 1'b0, mem_block(32'h40));
        #1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = {8{$urandom}};
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        vectors++;
        if ({bus.mem_req, bus.way_blk_write} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_ack got req %b blk_write %b want 0 0", bus.mem_req, bus.way_blk_write);
        end
        @(negedge clk);
        run_req(32'h40, 1'b1, 1'b0, 32'h0, 1, 1);
        vectors++;
        if (lat !== 0 || bus.hit_cnt !== CNT_W'(1)) begin
            miscompares++;
            $display("FAIL idle_ack_hit got lat %0d hit %0d want 0 1", lat, bus.hit_cnt);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        preload(32'h40, 1'b0, mem_block(32'h40));
        for (int i = 0; i < 254; i++) run_req(32'h40, 1'b1, 1'b0, 32'h0, 1, 1);
        vectors++;
        if (bus.hit_cnt !== CNT_MAX - 1'b1) begin
            miscompares++;
            $display("FAIL sat_hit_below got %0d want %0d", bus.hit_cnt, CNT_MAX - 1'b1);
        end
        for (int i = 0; i < 6; i++) run_req(32'h40, 1'b1, 1'b0, 32'h0, 1, 1);
        vectors++;
        if (bus.hit_cnt !== CNT_MAX) begin
            miscompares++;
            $display("FAIL sat_hit got %0d want %0d", bus.hit_cnt, CNT_MAX);
        end
        apply_reset();
        preload(32'h40, 1'b0, mem_block(32'h40));
        for (int i = 0; i < 258; i++) run_req((i % 2 == 0) ? 32'h1040 : 32'h40, 1'b1, 1'b0, 32'h0, 1, 1);
        vectors++;
        if (bus.miss_cnt !== CNT_MAX || bus.hit_cnt !== '0) begin
            miscompares++;
            $display("FAIL sat_miss got miss %0d hit %0d want %0d 0", bus.miss_cnt, bus.hit_cnt, CNT_MAX);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]      addr, wd, victim_addr;
        logic [255:0]     victim_data;
        logic             re, we, exp_hit, exp_dirty;
        logic [2:0]       s;
        logic [CNT_W-1:0] eh, em;
        int               op, wbw, rfw, exp_lat, exp_n;
        apply_reset();
        eh = '0;
        em = '0;
        for (int n = 0; n < 300; n++) begin
            addr = {22'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00};
            op   = $urandom_range(0, 2);
            re   = (op != 1);
            we   = (op != 0);
            wd   = $urandom;
            wbw  = $urandom_range(1, 4);
            rfw  = $urandom_range(1, 4);
            s    = addr[7:5];
            exp_hit     = w_valid[s] && (w_tag[s] == addr[31:8]);
            exp_dirty   = !exp_hit && w_valid[s] && w_dirty[s];
            victim_addr = {w_tag[s], s, 5'd0};
            victim_data = w_data[s];
            exp_lat = exp_hit ? 0 : (exp_dirty ? wbw + rfw + 2 : rfw + 2);
            exp_n   = exp_hit ? 0 : (exp_dirty ? 2 : 1);
            if (exp_hit) begin
                if (eh != CNT_MAX) eh = eh + 1'b1;
            end else if (em != CNT_MAX) begin
                em = em + 1'b1;
            end
            run_req(addr, re, we, wd, wbw, rfw);
            vectors++;
            if (lat !== exp_lat) begin
                miscompares++;
                $display("FAIL rnd_latency op %0d addr %h got %0d want %0d", n, addr, lat, exp_lat);
            end
            vectors++;
            if (obs_we.size() !== exp_n) begin
                miscompares++;
                $display("FAIL rnd_req_count op %0d got %0d want %0d", n, obs_we.size(), exp_n);
            end else if (exp_n != 0) begin
                if (exp_dirty && {obs_we[0], obs_addr[0], obs_wdata[0]} !== {1'b1, victim_addr, victim_data}) begin
                    miscompares++;
                    $display("FAIL rnd_wb op %0d got we %b addr %h want 1 %h", n, obs_we[0], obs_addr[0], victim_addr);
                end
                if ({obs_we[exp_n-1], obs_addr[exp_n-1]} !== {1'b0, addr[31:5], 5'd0}) begin
                    miscompares++;
                    $display("FAIL rnd_refill op %0d got we %b addr %h want 0 %h", n, obs_we[exp_n-1], obs_addr[exp_n-1], {addr[31:5], 5'd0});
                end
            end
            vectors++;
            if (stab_bad !== 0 || {rdy_done, rdy_we, rdy_re} !== {1'b1, we, re & ~we}) begin
                miscompares++;
                $display("FAIL rnd_handshake op %0d got stab %0d done/we/re %b want 0 %b", n, stab_bad, {rdy_done, rdy_we, rdy_re}, {1'b1, we, re & ~we});
            end
            if (we) begin
                golden[addr] = wd;
            end else begin
                vectors++;
                if (rdy_word !== gold_word(addr)) begin
                    miscompares++;
                    $display("FAIL rnd_read_data op %0d addr %h got %h want %h", n, addr, rdy_word, gold_word(addr));
                end
            end
            vectors++;
            if (bus.hit_cnt !== eh || bus.miss_cnt !== em) begin
                miscompares++;
                $display("FAIL rnd_counters op %0d got hit %0d miss %0d want %0d %0d", n, bus.hit_cnt, bus.miss_cnt, eh, em);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_clean_miss();
        test_dirty_write_miss();
        test_rw_both();
        test_reset_mid_refill();
        test_spurious_ack();
        test_saturation();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
